time_set_ctrl: RTL and testbench

Timekeeping and time-set controller for the 12-hour LCD clock. It holds the hh:mm:ss AM/PM registers and advances them on the 1 Hz tick. It runs the write-mode state machine, driven by debounced button pulses, that selects a field and increments or decrements it. It feeds the LCD formatter/driver and flags every visible change so the display refreshes.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/wrap_counter.sv | 33 +++
 rtl/time_set_ctrl.sv | 166 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared field encodings, limits and widths for the 12-hour clock timekeeper.
package clock_pkg;
  localparam int HH_W = 4;
  localparam int MM_W = 6;
  localparam int SS_W = 6;

  localparam int SS_MAX = 59;
  localparam int MM_MAX = 59;
  localparam int HH_MIN = 1;
  localparam int HH_MAX = 12;

  typedef enum logic [1:0] {
    FIELD_SS = 2'd0,
    FIELD_MM = 2'd1,
    FIELD_HH = 2'd2,
    FIELD_PM = 2'd3
  } field_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } state_t;
endpackage

// File: rtl/wrap_counter.sv
// Bounded up/down counter wrapping between MIN and MAX; carry flags the MAX->MIN increment.
module wrap_counter #(
  parameter int W       = 6,
  parameter int MIN     = 0,
  parameter int MAX     = 59,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         carry
);
  logic out_of_range;

  // Any illegal value is pulled back to MIN by the next step in either direction.
  assign out_of_range = (int'(value) < MIN) || (int'(value) > MAX);
  assign carry        = inc && !dec && (value == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= W'(RST_VAL);
    end else if (inc && !dec) begin
      value <= (out_of_range || value == W'(MAX)) ? W'(MIN) : value + 1'b1;
    end else if (dec && !inc) begin
      if (out_of_range)
        value <= W'(MIN);
      else
        value <= (value == W'(MIN)) ? W'(MAX) : value - 1'b1;
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// hh:mm:ss AM/PM timekeeper with button-driven edit mode for the LCD clock.
// Optional macro TIME_SET_AUTO_EXIT_EN: leave edit mode after TIMEOUT_S idle seconds.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_tick_1hz,
  input  logic            i_wr_p,
  input  logic            i_sel_inc_p,
  input  logic            i_sel_dec_p,
  input  logic            i_val_inc_p,
  input  logic            i_val_dec_p,
  output logic [HH_W-1:0] o_hh,
  output logic [MM_W-1:0] o_mm,
  output logic [SS_W-1:0] o_ss,
  output logic            o_pm,
  output logic            o_wr,
  output logic [1:0]      o_sel,
  output logic            o_upd
);
  if (TIMEOUT_S < 1) begin : g_bad_timeout
    $error("TIMEOUT_S must be at least 1");
  end

  state_t state_q, state_d;
  field_t sel_q, sel_d;
  logic   pm_q, upd_q, upd_d;
  logic   e_ss_inc, e_ss_dec, e_mm_inc, e_mm_dec, e_hh_inc, e_hh_dec, e_pm_tgl;
  logic   ss_inc, ss_dec, mm_inc, mm_dec, hh_inc, hh_dec, pm_tgl;
  logic   ss_carry, mm_carry, hh_carry;
  logic   run_q, run_tick, cnt_chg;

`ifdef TIME_SET_AUTO_EXIT_EN
  localparam int TMO_W = $clog2(TIMEOUT_S + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_clr, tmo_tick, tmo_exp;

  assign tmo_exp = (tmo_q == TMO_W'(TIMEOUT_S - 1));

  // Idle-second counter; held at zero outside edit mode so entry always starts fresh.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      tmo_q <= '0;
    else if (state_q != ST_EDIT || tmo_clr)
      tmo_q <= '0;
    else if (tmo_tick)
      tmo_q <= tmo_q + 1'b1;
  end
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    e_ss_inc = 1'b0;
    e_ss_dec = 1'b0;
    e_mm_inc = 1'b0;
    e_mm_dec = 1'b0;
    e_hh_inc = 1'b0;
    e_hh_dec = 1'b0;
    e_pm_tgl = 1'b0;
`ifdef TIME_SET_AUTO_EXIT_EN
    tmo_clr  = 1'b0;
    tmo_tick = 1'b0;
`endif
    case (state_q)
      ST_RUN: begin
        if (i_wr_p) begin
          state_d = ST_EDIT;
          sel_d   = FIELD_SS;
        end
      end
      ST_EDIT: begin
        if (i_wr_p) begin
          state_d = ST_RUN;
        end else if (i_sel_inc_p || i_sel_dec_p) begin
          if (i_sel_inc_p && !i_sel_dec_p)
            sel_d = field_t'(sel_q + 2'd1);
          else if (i_sel_dec_p && !i_sel_inc_p)
            sel_d = field_t'(sel_q - 2'd1);
`ifdef TIME_SET_AUTO_EXIT_EN
          tmo_clr = 1'b1;
`endif
        end else if (i_val_inc_p != i_val_dec_p) begin
          case (sel_q)
            FIELD_SS: begin
              e_ss_inc = i_val_inc_p;
              e_ss_dec = i_val_dec_p;
            end
            FIELD_MM: begin
              e_mm_inc = i_val_inc_p;
              e_mm_dec = i_val_dec_p;
            end
            FIELD_HH: begin
              e_hh_inc = i_val_inc_p;
              e_hh_dec = i_val_dec_p;
            end
            default: e_pm_tgl = 1'b1;
          endcase
`ifdef TIME_SET_AUTO_EXIT_EN
          tmo_clr = 1'b1;
`endif
        end
`ifdef TIME_SET_AUTO_EXIT_EN
        else if (i_tick_1hz) begin
          tmo_tick = 1'b1;
          if (tmo_exp)
            state_d = ST_RUN;
        end
`endif
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Carries ripple only while running; edits wrap a single field in isolation.
  assign run_q    = (state_q == ST_RUN);
  assign run_tick = run_q && i_tick_1hz;
  assign ss_inc   = run_tick | e_ss_inc;
  assign ss_dec   = e_ss_dec;
  assign mm_inc   = (run_q && ss_carry) | e_mm_inc;
  assign mm_dec   = e_mm_dec;
  assign hh_inc   = (run_q && mm_carry) | e_hh_inc;
  assign hh_dec   = e_hh_dec;
  assign pm_tgl   = (run_q && mm_carry && o_hh == HH_W'(11)) | e_pm_tgl;

  // Every counter step moves its value, so step requests alone identify a change.
  assign cnt_chg = ss_inc | ss_dec | mm_inc | mm_dec | hh_inc | hh_dec | hh_carry;
  assign upd_d   = cnt_chg | pm_tgl | (state_d != state_q) | (sel_d != sel_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_RUN;
      sel_q   <= FIELD_SS;
      pm_q    <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pm_q    <= pm_q ^ pm_tgl;
      upd_q   <= upd_d;
    end
  end

  wrap_counter #(.W(SS_W), .MIN(0), .MAX(SS_MAX), .RST_VAL(0)) u_ss (
    .clk(i_clk), .rst_n(i_reset_n), .inc(ss_inc), .dec(ss_dec),
    .value(o_ss), .carry(ss_carry)
  );

  wrap_counter #(.W(MM_W), .MIN(0), .MAX(MM_MAX), .RST_VAL(0)) u_mm (
    .clk(i_clk), .rst_n(i_reset_n), .inc(mm_inc), .dec(mm_dec),
    .value(o_mm), .carry(mm_carry)
  );

  wrap_counter #(.W(HH_W), .MIN(HH_MIN), .MAX(HH_MAX), .RST_VAL(HH_MAX)) u_hh (
    .clk(i_clk), .rst_n(i_reset_n), .inc(hh_inc), .dec(hh_dec),
    .value(o_hh), .carry(hh_carry)
  );

  assign o_pm  = pm_q;
  assign o_wr  = (state_q == ST_EDIT);
  assign o_sel = sel_q;
  assign o_upd = upd_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a behavioural clock model predicts every cycle.
module tb_time_set_ctrl;
  localparam int TB_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick, wr, si, sd, vi, vd;
  logic [3:0] hh;
  logic [5:0] mm, ss;
  logic       pm, wr_o, upd;
  logic [1:0] sel;

  time_set_ctrl #(.TIMEOUT_S(TB_TIMEOUT)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_tick_1hz(tick), .i_wr_p(wr),
    .i_sel_inc_p(si), .i_sel_dec_p(sd), .i_val_inc_p(vi), .i_val_dec_p(vd),
    .o_hh(hh), .o_mm(mm), .o_ss(ss), .o_pm(pm), .o_wr(wr_o), .o_sel(sel), .o_upd(upd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hh; int mm; int ss; int pm; int wr; int sel; int upd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_hh, m_mm, m_ss, m_pm, m_wr, m_sel, m_tmo;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hh = 12; m_mm = 0; m_ss = 0; m_pm = 0; m_wr = 0; m_sel = 0; m_tmo = 0;
  endtask

  task automatic model_step(input bit t, input bit w, input bit a, input bit b,
                            input bit c, input bit d, output exp_t e);
    int oh, om, os, op, ow, osel;
    oh = m_hh; om = m_mm; os = m_ss; op = m_pm; ow = m_wr; osel = m_sel;
    if (m_wr == 0) begin
      if (t) begin
        if (m_ss < 59) m_ss++;
        else begin
          m_ss = 0;
          if (m_mm < 59) m_mm++;
          else begin
            m_mm = 0;
            if (m_hh == 12) m_hh = 1;
            else begin
              m_hh++;
              if (m_hh == 12) m_pm = 1 - m_pm;
            end
          end
        end
      end
      if (w) begin m_wr = 1; m_sel = 0; m_tmo = 0; end
    end else if (w) begin
      m_wr = 0;
    end else if (a || b) begin
      if (a && !b) m_sel = (m_sel + 1) % 4;
      else if (b && !a) m_sel = (m_sel + 3) % 4;
      m_tmo = 0;
    end else if (c != d) begin
      case (m_sel)
        0: m_ss = c ? (m_ss + 1) % 60 : (m_ss + 59) % 60;
        1: m_mm = c ? (m_mm + 1) % 60 : (m_mm + 59) % 60;
        2: m_hh = c ? (m_hh % 12) + 1 : ((m_hh + 10) % 12) + 1;
        default: m_pm = 1 - m_pm;
      endcase
      m_tmo = 0;
    end else if (t) begin
`ifdef TIME_SET_AUTO_EXIT_EN
      m_tmo++;
      if (m_tmo == TB_TIMEOUT) m_wr = 0;
`endif
    end
    e.hh = m_hh; e.mm = m_mm; e.ss = m_ss; e.pm = m_pm; e.wr = m_wr; e.sel = m_sel;
    e.upd = (oh != m_hh || om != m_mm || os != m_ss || op != m_pm ||
             ow != m_wr || osel != m_sel) ? 1 : 0;
  endtask

  task automatic step(input bit t, input bit w, input bit a, input bit b,
                      input bit c, input bit d);
    exp_t e;
    tick = t; wr = w; si = a; sd = b; vi = c; vd = d;
    model_step(t, w, a, b, c, d, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    tick = 0; wr = 0; si = 0; sd = 0; vi = 0; vd = 0;
    e = sb_q.pop_front();
    chk_val("hh", int'(hh), e.hh);
    chk_val("mm", int'(mm), e.mm);
    chk_val("ss", int'(ss), e.ss);
    chk_val("pm", int'(pm), e.pm);
    chk_val("wr", int'(wr_o), e.wr);
    chk_val("sel", int'(sel), e.sel);
    chk_val("upd", int'(upd), e.upd);
  endtask

  // T tick, W wr, S/s sel inc/dec, V/v val inc/dec, X val inc+dec,
  // Y wr+val inc, Z tick+wr, Q tick+val inc, . idle
  task automatic run_seq(input string s);
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "T": step(1, 0, 0, 0, 0, 0);
        "W": step(0, 1, 0, 0, 0, 0);
        "S": step(0, 0, 1, 0, 0, 0);
        "s": step(0, 0, 0, 1, 0, 0);
        "V": step(0, 0, 0, 0, 1, 0);
        "v": step(0, 0, 0, 0, 0, 1);
        "X": step(0, 0, 0, 0, 1, 1);
        "Y": step(0, 1, 0, 0, 1, 0);
        "Z": step(1, 1, 0, 0, 0, 0);
        "Q": step(1, 0, 0, 0, 1, 0);
        default: step(0, 0, 0, 0, 0, 0);
      endcase
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int p);
    chk_val({tag, "_hh"}, int'(hh), h);
    chk_val({tag, "_mm"}, int'(mm), m);
    chk_val({tag, "_ss"}, int'(ss), s);
    chk_val({tag, "_pm"}, int'(pm), p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    tick = 0; wr = 0; si = 0; sd = 0; vi = 0; vd = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_time("rst", 12, 0, 0, 0);
    chk_val("rst_wr", int'(wr_o), 0);
    chk_val("rst_sel", int'(sel), 0);
    chk_val("rst_upd", int'(upd), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 60; i++) run_seq("T");
    chk_time("tick60", 12, 1, 0, 0);
    chk_val("tick60_upd", int'(upd), 1);
    run_seq("T");
    chk_time("tick61", 12, 1, 1, 0);

    run_seq("WSvvSvssvvW");
    chk_time("set_am", 11, 59, 59, 0);
    run_seq("T");
    chk_time("roll_pm", 12, 0, 0, 1);
    run_seq("WSvSvssvW");
    chk_time("set_pm", 11, 59, 59, 1);
    run_seq("T");
    chk_time("roll_am", 12, 0, 0, 0);

    run_seq("TTTTT");
    run_seq("WSV");
    chk_time("btn_mm", 12, 1, 5, 0);
    run_seq("Sv");
    chk_time("btn_hh", 11, 1, 5, 0);
    run_seq("SvVV");
    chk_val("btn_pm", int'(pm), 1);
    run_seq("Svvvv");
    chk_val("btn_ss", int'(ss), 1);
    run_seq("Svv");
    run_seq("W");
    chk_time("btn_exit", 11, 59, 1, 1);
    chk_val("btn_exit_wr", int'(wr_o), 0);
    run_seq("TT");

    run_seq("Ws");
    chk_val("sel_wrap", int'(sel), 3);
    run_seq("Svvvv");
    chk_val("ss_wrap", int'(ss), 59);
    chk_val("ss_wrap_mm", int'(mm), 59);
    run_seq("SSVVv");
    chk_val("hh_wrap", int'(hh), 12);
    chk_val("hh_wrap_pm", int'(pm), 1);

    run_seq("X");
    chk_val("cancel_upd", int'(upd), 0);
    run_seq("Y");
    chk_val("wr_val_wr", int'(wr_o), 0);
    chk_val("wr_val_hh", int'(hh), 12);
    run_seq("Z");
    chk_val("tick_wr_ss", int'(ss), 0);
    chk_val("tick_wr_wr", int'(wr_o), 1);
    run_seq("TTTTT");

    if (m_wr == 0) run_seq("W");
    run_seq("SV");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_time("async_rst", 12, 0, 0, 0);
    chk_val("async_rst_wr", int'(wr_o), 0);
    chk_val("async_rst_sel", int'(sel), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    run_seq("WTTT");
`ifdef TIME_SET_AUTO_EXIT_EN
    chk_val("tmo_exit_wr", int'(wr_o), 0);
`endif
    if (m_wr == 0) run_seq("W");
    run_seq("TQTT");
`ifdef TIME_SET_AUTO_EXIT_EN
    chk_val("tmo_restart_wr", int'(wr_o), 1);
`endif
    run_seq("T");
`ifdef TIME_SET_AUTO_EXIT_EN
    chk_val("tmo_exit2_wr", int'(wr_o), 0);
`endif
    run_seq("..T");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
